// File: rtl/alu_wb_stage.sv
// Execute/writeback stage: ALU with multi-cycle ROT3, hazard interlock.
// Define ALU_WB_FWD_EN to forward wb_data into operands instead of stalling.
module alu_wb_stage #(
    parameter int DW = 24,
    parameter int AW = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_dst,
    input  logic [AW-1:0] in_src0,
    input  logic [AW-1:0] in_src1,
    output logic [AW-1:0] rf_src0,
    output logic [AW-1:0] rf_src1,
    input  logic [DW-1:0] rf_outa,
    input  logic [DW-1:0] rf_outb,
    output logic          wb_we,
    output logic [AW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    output logic          busy
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_ROT = 4'd7;

    typedef enum logic {S_EXEC, S_ROT} state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_e_valid;
    logic [3:0]    r_e_op;
    logic [AW-1:0] r_e_dst;
    logic [DW-1:0] r_e_a;
    logic [DW-1:0] r_e_b;
    logic [CW-1:0] r_cnt;
    logic          r_w_valid;
    logic [AW-1:0] r_wb_dst;
    logic [DW-1:0] r_wb_data;

    logic          w_e_wr;
    logic          w_e_done;
    logic          w_haz_e;
    logic          w_haz_w;
    logic          w_hit0;
    logic          w_hit1;
    logic          w_xfer;
    logic [DW-1:0] w_opa;
    logic [DW-1:0] w_opb;
    logic [DW-1:0] w_res;

    assign rf_src0 = in_src0;
    assign rf_src1 = in_src1;

    // Only opcodes 1..7 write the regfile; 0 and 8..15 pass through silently.
    assign w_e_wr   = r_e_valid && !r_e_op[3] && (r_e_op != 4'd0);
    assign w_e_done = r_e_valid && (r_state == S_EXEC);
    assign w_haz_e  = w_e_wr &&
                      ((r_e_dst == in_src0) || (r_e_dst == in_src1));
    assign w_hit0   = r_w_valid && (r_wb_dst == in_src0);
    assign w_hit1   = r_w_valid && (r_wb_dst == in_src1);

`ifdef ALU_WB_FWD_EN
    assign w_haz_w = 1'b0;
    assign w_opa   = w_hit0 ? r_wb_data : rf_outa;
    assign w_opb   = w_hit1 ? r_wb_data : rf_outb;
`else
    assign w_haz_w = w_hit0 || w_hit1;
    assign w_opa   = rf_outa;
    assign w_opb   = rf_outb;
`endif

    assign in_ready = (!r_e_valid || w_e_done) && !w_haz_e && !w_haz_w;
    assign w_xfer   = in_valid && in_ready;

    // ROT3 reaches S_EXEC with A already rotated, so it completes as MOV.
    always_comb begin
        w_res = r_e_a;
        case (r_e_op)
            OP_ADD:  w_res = r_e_a + r_e_b;
            OP_SUB:  w_res = r_e_a - r_e_b;
            OP_AND:  w_res = r_e_a & r_e_b;
            OP_OR:   w_res = r_e_a | r_e_b;
            OP_XOR:  w_res = r_e_a ^ r_e_b;
            default: w_res = r_e_a;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_xfer) begin
            if (in_op == OP_ROT && w_opb[CW-1:0] != '0)
                w_state_nx = S_ROT;
            else
                w_state_nx = S_EXEC;
        end else if (r_state == S_ROT && r_cnt == CW'(1)) begin
            w_state_nx = S_EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_EXEC;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e_op    <= '0;
            r_e_dst   <= '0;
            r_e_a     <= '0;
            r_e_b     <= '0;
            r_cnt     <= '0;
        end else if (w_xfer) begin
            r_e_valid <= 1'b1;
            r_e_op    <= in_op;
            r_e_dst   <= in_dst;
            r_e_a     <= w_opa;
            r_e_b     <= w_opb;
            r_cnt     <= (in_op == OP_ROT) ? w_opb[CW-1:0] : '0;
        end else if (w_e_done) begin
            r_e_valid <= 1'b0;
        end else if (r_state == S_ROT) begin
            r_e_a <= {r_e_a[DW-4:0], r_e_a[DW-1:DW-3]};
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_valid <= 1'b0;
            r_wb_dst  <= '0;
            r_wb_data <= '0;
        end else begin
            r_w_valid <= w_e_done && w_e_wr;
            if (w_e_done && w_e_wr) begin
                r_wb_dst  <= r_e_dst;
                r_wb_data <= w_res;
            end
        end
    end

    assign wb_we   = r_w_valid;
    assign wb_dst  = r_wb_dst;
    assign wb_data = r_wb_data;
    assign busy    = r_e_valid | r_w_valid;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Scoreboard bench for alu_wb_stage with a behavioural regfile.
module tb_alu_wb_stage;

`ifdef ALU_WB_FWD_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 3;
`endif

    localparam logic [23:0] RV [16] = '{
        24'h840204, 24'h111111, 24'h203800, 24'h333333,
        24'h444444, 24'h555555, 24'h666666, 24'h1F58D1,
        24'h888888, 24'h999999, 24'hAAAAAA, 24'hBBBBBB,
        24'h000001, 24'h000000, 24'h000009, 24'h00000F
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [3:0]  in_dst = '0;
    logic [3:0]  in_src0 = '0;
    logic [3:0]  in_src1 = '0;
    logic [3:0]  rf_src0;
    logic [3:0]  rf_src1;
    logic [23:0] rf_outa;
    logic [23:0] rf_outb;
    logic        wb_we;
    logic [3:0]  wb_dst;
    logic [23:0] wb_data;
    logic        busy;

    logic [23:0] rf [16];
    logic [23:0] mdl [16];
    bit          rf_loaded = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [27:0] exp_q [$];
    int          wr_cyc [$];

    alu_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_dst(in_dst),
        .in_src0(in_src0), .in_src1(in_src1),
        .rf_src0(rf_src0), .rf_src1(rf_src1),
        .rf_outa(rf_outa), .rf_outb(rf_outb),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 16; i++) rf[i] <= RV[i];
        end else if (wb_we) begin
            rf[wb_dst] <= wb_data;
        end
    end

    assign rf_outa = rf[rf_src0];
    assign rf_outb = rf[rf_src1];

    // Scoreboard: every write must match the oldest pending expectation.
    always @(negedge clk) begin
        logic [27:0] e;
        if (rst_n && wb_we) begin
            wr_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write dst=%0d data=%06h", wb_dst, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_dst !== e[27:24]) begin
                    errors++;
                    $display("FAIL wb_dst got=%0d exp=%0d", wb_dst, e[27:24]);
                end
                checks++;
                if (wb_data !== e[23:0]) begin
                    errors++;
                    $display("FAIL wb_data got=%06h exp=%06h", wb_data, e[23:0]);
                end
            end
        end
    end

    function automatic logic [23:0] alu(input logic [3:0] op,
                                        input logic [23:0] a,
                                        input logic [23:0] b);
        logic [23:0] r;
        case (op)
            4'd1: r = a + b;
            4'd2: r = a - b;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = a;
            4'd7: begin
                r = a;
                for (int k = 0; k < int'(b[2:0]); k++)
                    r = {r[20:0], r[23:21]};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic send(input logic [3:0] op, input logic [3:0] dst,
                        input logic [3:0] s0, input logic [3:0] s1,
                        input bit push, output int t);
        int n = 0;
        logic [23:0] r;
        in_op = op;
        in_dst = dst;
        in_src0 = s0;
        in_src1 = s1;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d got_ready=0 exp_ready=1", op);
        end else if (push && op != 4'd0 && op <= 4'd7) begin
            r = alu(op, mdl[s0], mdl[s1]);
            exp_q.push_back({dst, r});
            mdl[dst] = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int k = 0;
        while (wr_cyc.size() < n && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (wr_cyc.size() < n) begin
            checks++;
            errors++;
            $display("FAIL write_timeout got=%0d exp=%0d", wr_cyc.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_wb_we got=%b exp=0", wb_we);
        end
        checks++;
        if (wb_dst !== 4'd0) begin
            errors++;
            $display("FAIL rst_wb_dst got=%0d exp=0", wb_dst);
        end
        checks++;
        if (wb_data !== 24'd0) begin
            errors++;
            $display("FAIL rst_wb_data got=%06h exp=0", wb_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        rf_loaded = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_single(input logic [3:0] op, input logic [3:0] d,
                                   input logic [3:0] a, input logic [3:0] b);
        int t;
        wr_cyc.delete();
        send(op, d, a, b, 1'b1, t);
        idle();
        wait_writes(1);
        checks++;
        if (wr_cyc.size() < 1 || wr_cyc[0] - t != 2) begin
            errors++;
            $display("FAIL latency_op%0d got=%0d exp=2", op,
                     wr_cyc.size() ? wr_cyc[0] - t : -1);
        end
    endtask

    task automatic test_rot();
        int t;
        wr_cyc.delete();
        send(4'd7, 4'd8, 4'd7, 4'd14, 1'b1, t);
        idle();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rot_stall got=%b exp=0", in_ready);
        end
        wait_writes(1);
        checks++;
        if (wr_cyc.size() < 1 || wr_cyc[0] - t != 3) begin
            errors++;
            $display("FAIL rot_k1_latency got=%0d exp=3",
                     wr_cyc.size() ? wr_cyc[0] - t : -1);
        end
        checks++;
        if (rf[8] !== 24'hFAC688) begin
            errors++;
            $display("FAIL rot_k1_r8 got=%06h exp=fac688", rf[8]);
        end
        test_alu_single(4'd7, 4'd8, 4'd7, 4'd13);
    endtask

    task automatic test_dependent();
        int t1;
        int t2;
        wr_cyc.delete();
        send(4'd1, 4'd4, 4'd12, 4'd12, 1'b1, t1);
        send(4'd1, 4'd5, 4'd4, 4'd12, 1'b1, t2);
        idle();
        wait_writes(2);
        checks++;
        if (t2 - t1 != GAP) begin
            errors++;
            $display("FAIL dep_accept_gap got=%0d exp=%0d", t2 - t1, GAP);
        end
        checks++;
        if (wr_cyc.size() < 2 || wr_cyc[1] - wr_cyc[0] != GAP) begin
            errors++;
            $display("FAIL dep_write_gap got=%0d exp=%0d",
                     wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, GAP);
        end
        checks++;
        if (rf[5] !== 24'h000003) begin
            errors++;
            $display("FAIL dep_r5 got=%06h exp=000003", rf[5]);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int t3;
        wr_cyc.delete();
        send(4'd1, 4'd1, 4'd0, 4'd12, 1'b1, t1);
        send(4'd5, 4'd6, 4'd2, 4'd7, 1'b1, t2);
        send(4'd3, 4'd9, 4'd7, 4'd0, 1'b1, t3);
        idle();
        wait_writes(3);
        checks++;
        if (t2 != t1 + 1 || t3 != t2 + 1) begin
            errors++;
            $display("FAIL b2b_accept got=%0d,%0d exp=1,1", t2 - t1, t3 - t2);
        end
        checks++;
        if (wr_cyc.size() < 3 || wr_cyc[2] != t1 + 4) begin
            errors++;
            $display("FAIL b2b_last_write got=%0d exp=4",
                     wr_cyc.size() > 2 ? wr_cyc[2] - t1 : -1);
        end
    endtask

    task automatic test_reserved();
        int t1;
        int t2;
        wr_cyc.delete();
        send(4'hF, 4'd10, 4'd2, 4'd0, 1'b1, t1);
        send(4'd6, 4'd10, 4'd2, 4'd0, 1'b1, t2);
        idle();
        wait_writes(1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (t2 - t1 != 1) begin
            errors++;
            $display("FAIL rsvd_throughput got=%0d exp=1", t2 - t1);
        end
        checks++;
        if (wr_cyc.size() != 1 || wr_cyc[0] - t2 != 2) begin
            errors++;
            $display("FAIL rsvd_writes got=%0d exp=1", wr_cyc.size());
        end
        checks++;
        if (rf[10] !== 24'h203800) begin
            errors++;
            $display("FAIL rsvd_r10 got=%06h exp=203800", rf[10]);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        wr_cyc.delete();
        send(4'd7, 4'd8, 4'd7, 4'd15, 1'b0, t);
        idle();
        while (cyc < t + 3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wb_we !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_state got=%b%b exp=00", busy, wb_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_busy got=%b exp=0", busy);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_rst_ready got=%b exp=1", in_ready);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (wr_cyc.size() != 0) begin
            errors++;
            $display("FAIL mid_rst_writes got=%0d exp=0", wr_cyc.size());
        end
        checks++;
        if (rf[8] !== mdl[8]) begin
            errors++;
            $display("FAIL mid_rst_r8 got=%06h exp=%06h", rf[8], mdl[8]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = RV[i];
        test_reset();
        test_alu_single(4'd1, 4'd3, 4'd0, 4'd12);
        test_alu_single(4'd2, 4'd3, 4'd13, 4'd12);
        test_rot();
        test_dependent();
        test_back_to_back();
        test_reserved();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expected got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
